keystream_xor_encryptor: RTL and testbench

//   Byte-serial stream-cipher stage sitting directly downstream of hash_generator.

---
 rtl/keystream_xor_encryptor.sv | 118 +++++++++++
 tb/tb_keystream_xor_encryptor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keystream_xor_encryptor.sv
// Byte-serial stream-cipher stage: fetches one keystream byte per plaintext byte
// from hash_generator and presents plaintext ^ keystream on a valid/ready output.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a plaintext byte
// REQUEST  | request_hash_byte_pulse high this cycle, keystream timer armed
// WAIT_KEY | waiting for hash_byte_pulse_in, timer counting down
// OUTPUT   | ciphertext held on data_out until downstream accepts
module keystream_xor_encryptor #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   msg_start,
    input  logic [7:0]             data_in,
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    output logic                   request_hash_byte_pulse,
    input  logic [7:0]             hash_byte_in,
    input  logic                   hash_byte_pulse_in,
    output logic                   reset_hash,
    output logic [7:0]             data_out,
    output logic                   data_out_valid,
    input  logic                   data_out_ready,
    output logic [COUNT_WIDTH-1:0] byte_count,
    output logic                   timeout_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        WAIT_KEY = 2'd2,
        OUTPUT   = 2'd3
    } state_t;

    state_t                 state_q;
    logic [7:0]             data_q;
    logic [TW-1:0]          timer_q;
    logic                   req_q;
    logic                   rst_hash_q;
    logic [7:0]             dout_q;
    logic                   dout_valid_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   terr_q;

    assign data_in_ready           = (state_q == IDLE) && !msg_start;
    assign request_hash_byte_pulse = req_q;
    assign reset_hash              = rst_hash_q;
    assign data_out                = dout_q;
    assign data_out_valid          = dout_valid_q;
    assign byte_count              = count_q;
    assign timeout_err             = terr_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            data_q       <= '0;
            timer_q      <= '0;
            req_q        <= 1'b0;
            rst_hash_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            count_q      <= '0;
            terr_q       <= 1'b0;
        end else begin
            req_q      <= 1'b0;
            rst_hash_q <= 1'b0;
            if (msg_start) begin
                // New message: drop any in-flight byte and restart the keystream.
                state_q      <= IDLE;
                dout_valid_q <= 1'b0;
                count_q      <= '0;
                terr_q       <= 1'b0;
                rst_hash_q   <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (data_in_valid) begin
                            data_q  <= data_in;
                            req_q   <= 1'b1;
                            state_q <= REQUEST;
                        end
                    end
                    REQUEST: begin
                        timer_q <= TIMER_LOAD;
                        state_q <= WAIT_KEY;
                    end
                    WAIT_KEY: begin
                        timer_q <= timer_q - 1'b1;
                        // A key pulse arriving on the terminal cycle still wins.
                        if (hash_byte_pulse_in) begin
                            dout_q       <= data_q ^ hash_byte_in;
                            dout_valid_q <= 1'b1;
                            state_q      <= OUTPUT;
                        end else if (timer_q == '0) begin
                            terr_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    OUTPUT: begin
                        if (data_out_ready) begin
                            count_q      <= count_q + 1'b1;
                            dout_valid_q <= 1'b0;
                            state_q      <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keystream_xor_encryptor.sv
// Directed bench for keystream_xor_encryptor: stimulus pushes expected ciphertext
// into a queue, an independent monitor pops it on every output handshake.
module tb_keystream_xor_encryptor;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       msg_start = 1'b0;
    logic [7:0] data_in = '0;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       request_hash_byte_pulse;
    logic [7:0] hash_byte_in = '0;
    logic       hash_byte_pulse_in = 1'b0;
    logic       reset_hash;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready = 1'b1;
    logic [3:0] byte_count;
    logic       timeout_err;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    keystream_xor_encryptor #(.TIMEOUT_CYCLES(64), .COUNT_WIDTH(4)) dut (
        .clk                     (clk),
        .nrst                    (nrst),
        .msg_start               (msg_start),
        .data_in                 (data_in),
        .data_in_valid           (data_in_valid),
        .data_in_ready           (data_in_ready),
        .request_hash_byte_pulse (request_hash_byte_pulse),
        .hash_byte_in            (hash_byte_in),
        .hash_byte_pulse_in      (hash_byte_pulse_in),
        .reset_hash              (reset_hash),
        .data_out                (data_out),
        .data_out_valid          (data_out_valid),
        .data_out_ready          (data_out_ready),
        .byte_count              (byte_count),
        .timeout_err             (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completed output handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (nrst && data_out_valid && data_out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got %0h expected none", data_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    bad++;
                    $display("FAIL data_out: got %0h expected %0h", data_out, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!data_in_ready && n < 100) begin
            tick();
            n++;
        end
        check("send_ready", data_in_ready, 1'b1);
        data_in       = b;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
    endtask

    // Called in the REQUEST cycle; key pulse lands 'dly' cycles after the request.
    task automatic serve_key(input int dly, input logic [7:0] key, input logic [7:0] expv);
        check("req_high", request_hash_byte_pulse, 1'b1);
        tick();
        check("req_one_cycle", request_hash_byte_pulse, 1'b0);
        repeat (dly - 1) tick();
        exp_q.push_back(expv);
        hash_byte_in       = key;
        hash_byte_pulse_in = 1'b1;
        tick();
        hash_byte_pulse_in = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!data_out_valid && n < 20) begin
            tick();
            n++;
        end
        check("valid_seen", data_out_valid, 1'b1);
    endtask

    task automatic wait_drained();
        int n = 0;
        while (data_out_valid && n < 20) begin
            tick();
            n++;
        end
        check("valid_dropped", data_out_valid, 1'b0);
    endtask

    initial begin
        // Reset state
        #12;
        check("reset_outputs",
              {data_out, data_out_valid, request_hash_byte_pulse, reset_hash, byte_count, timeout_err},
              32'h0);
        tick();
        nrst = 1'b1;
        tick();

        // 1: basic byte 5A ^ 3C
        send_byte(8'h5A);
        serve_key(2, 8'h3C, 8'h66);
        wait_valid();
        wait_drained();
        check("count_after_1", byte_count, 4'd1);

        // 2: backpressure A5 ^ 0F
        data_out_ready = 1'b0;
        send_byte(8'hA5);
        serve_key(1, 8'h0F, 8'hAA);
        wait_valid();
        data_in = 8'h77;
        data_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_data", data_out, 8'hAA);
            check("hold_valid", data_out_valid, 1'b1);
            check("hold_in_ready", data_in_ready, 1'b0);
            check("hold_no_req", request_hash_byte_pulse, 1'b0);
            tick();
        end
        data_in_valid = 1'b0;
        data_out_ready = 1'b1;
        tick();
        check("accept_valid_drop", data_out_valid, 1'b0);
        check("count_after_2", byte_count, 4'd2);

        // 3: keystream timeout after 64 WAIT_KEY cycles
        send_byte(8'h11);
        repeat (64) tick();
        check("timeout_not_early", timeout_err, 1'b0);
        tick();
        check("timeout_set", timeout_err, 1'b1);
        check("timeout_idle", data_in_ready, 1'b1);
        check("timeout_no_valid", data_out_valid, 1'b0);
        send_byte(8'h22);
        serve_key(1, 8'h44, 8'h66);
        wait_valid();
        wait_drained();
        check("count_after_3", byte_count, 4'd3);
        check("timeout_sticky", timeout_err, 1'b1);

        // 4: msg_start during WAIT_KEY
        send_byte(8'h33);
        tick();
        msg_start = 1'b1;
        check("msg_in_ready_low", data_in_ready, 1'b0);
        tick();
        msg_start = 1'b0;
        check("reset_hash_pulse", reset_hash, 1'b1);
        check("msg_count_clear", byte_count, 4'd0);
        check("msg_terr_clear", timeout_err, 1'b0);
        tick();
        check("reset_hash_one", reset_hash, 1'b0);
        hash_byte_in = 8'hFF;
        hash_byte_pulse_in = 1'b1;
        tick();
        hash_byte_pulse_in = 1'b0;
        tick();
        check("late_key_ignored", data_out_valid, 1'b0);

        // back-to-back msg_start, then a byte accepted while reset_hash is high
        msg_start = 1'b1;
        tick();
        tick();
        msg_start = 1'b0;
        check("reset_hash_b2b", reset_hash, 1'b1);
        send_byte(8'h01);
        check("reset_hash_end", reset_hash, 1'b0);
        serve_key(2, 8'h80, 8'h81);
        wait_valid();
        wait_drained();
        check("count_after_4", byte_count, 4'd1);

        // 5: stray key pulse in IDLE, then counter wrap
        hash_byte_in = 8'h99;
        hash_byte_pulse_in = 1'b1;
        tick();
        hash_byte_pulse_in = 1'b0;
        tick();
        check("stray_no_valid", data_out_valid, 1'b0);
        check("stray_idle", data_in_ready, 1'b1);
        msg_start = 1'b1;
        tick();
        msg_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i * 16 + i));
            serve_key(1, 8'h0F, 8'(i * 16 + i) ^ 8'h0F);
            wait_valid();
            wait_drained();
            if (i == 14) check("count_15", byte_count, 4'd15);
        end
        check("count_wrap", byte_count, 4'd0);

        // 6: async reset while holding output
        data_out_ready = 1'b0;
        send_byte(8'hC3);
        serve_key(1, 8'h3C, 8'hFF);
        wait_valid();
        #2;
        nrst = 1'b0;
        #1;
        check("async_rst_outputs",
              {data_out, data_out_valid, request_hash_byte_pulse, reset_hash, byte_count, timeout_err},
              32'h0);
        exp_q.delete();
        data_out_ready = 1'b1;
        tick();
        nrst = 1'b1;
        tick();
        check("post_rst_idle", data_in_ready, 1'b1);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
